// File: rtl/ahb_prot_ram_pkg.sv
// Shared definitions for the protected AHB RAM: state encoding, AHB constants,
// address-phase parity and the 32->7 SEC-DED check-bit encoder.
package p_hardisc;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_CHK = 3'd1,
        WR_OK  = 3'd2,
        ERR1   = 3'd3,
        ERR2   = 3'd4
    } ahb_ram_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    function automatic logic [5:0] addr_parity(
        input logic [31:0] addr,
        input logic [1:0]  trans,
        input logic        write,
        input logic [2:0]  size,
        input logic [2:0]  burst,
        input logic [3:0]  prot,
        input logic        lock
    );
        addr_parity = {^{burst, prot, lock}, ^{trans, write, size},
                       ^addr[31:24], ^addr[23:16], ^addr[15:8], ^addr[7:0]};
    endfunction

    // Extended Hamming: data bits occupy the non-power-of-two positions 3..38,
    // bit 6 is the overall parity over data and the six Hamming bits.
    function automatic logic [6:0] secded_enc(input logic [31:0] d);
        logic [5:0] c;
        logic [4:0] j;
        c = 6'd0;
        j = 5'd0;
        for (int q = 1; q < 39; q++) begin
            if ((q & (q - 32'sd1)) != 32'sd0) begin
                if (d[j]) begin
                    c = c ^ 6'(q);
                end else begin
                    c = c;
                end
                j = j + 5'd1;
            end else begin
                j = j;
            end
        end
        secded_enc = {(^d) ^ (^c), c};
    endfunction

endpackage

// File: rtl/ahb_prot_ram_bytemerge.sv
// Byte-lane merge for AHB partial writes: selects the lanes addressed by
// hsize/addr[1:0] from the new word and keeps the rest of the old word.
module ahb_ram_bytemerge
    import p_hardisc::*;
(
    input  logic [2:0]  i_hsize,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    output logic [31:0] o_merged
);

    logic [3:0] w_be;

    // Lane enables and merged word
    always_comb begin
        w_be     = 4'b0000;
        o_merged = i_old;
        case (i_hsize)
            HSIZE_BYTE: w_be = 4'b0001 << i_addr;
            HSIZE_HALF: w_be = i_addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: w_be = 4'b1111;
            default:    w_be = 4'b0000;
        endcase
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                o_merged[8*b +: 8] = i_new[8*b +: 8];
            end else begin
                o_merged[8*b +: 8] = i_old[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_prot_ram.sv
// Protected AHB-Lite single-port RAM slave (zero-wait reads, one-wait checked writes).
// Build option PROT_RAM_STORE_ECC_EN stores the check bits in the RAM for end-to-end protection.
module ahb_prot_ram
    import p_hardisc::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [2:0]  s_hburst_i,
    input  logic        s_hmastlock_i,
    input  logic [3:0]  s_hprot_i,
    input  logic [2:0]  s_hsize_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic [5:0]  s_hparity_i,
    input  logic [6:0]  s_hwchecksum_i,
    output logic [31:0] s_hrdata_o,
    output logic        s_hready_o,
    output logic        s_hresp_o,
    output logic [6:0]  s_hrchecksum_o,
    output logic        s_err_o,
    output logic [7:0]  s_err_cnt_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
`ifdef PROT_RAM_STORE_ECC_EN
    localparam int unsigned MW = 39;
`else
    localparam int unsigned MW = 32;
`endif

    logic [MW-1:0]  r_mem [MEM_WORDS];
    ahb_ram_state_t r_state;
    ahb_ram_state_t w_state_nxt;
    logic           r_hready;
    logic           r_hresp;
    logic           r_err;
    logic [7:0]     r_err_cnt;
    logic [31:0]    r_hrdata;
    logic [6:0]     r_hrchk;
    logic [AW-1:0]  r_widx;
    logic [2:0]     r_wsize;
    logic [1:0]     r_wlane;
    logic [31:0]    r_old;

    logic           w_accept;
    logic           w_addr_fail;
    logic           w_chk_ok;
    logic           w_rd_go;
    logic           w_wr_go;
    logic           w_commit;
    logic [AW-1:0]  w_aidx;
    logic [31:0]    w_merged;
    logic [MW-1:0]  w_wword;

    assign w_accept = s_hsel_i & s_htrans_i[1] & r_hready;
    assign w_aidx   = s_haddr_i[AW+1:2];
    assign w_chk_ok = (s_hwchecksum_i == secded_enc(s_hwdata_i));

    // Address-phase protection checks: parity, range, size, alignment
    always_comb begin
        w_addr_fail = 1'b0;
        if (s_hparity_i != addr_parity(s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i,
                                       s_hburst_i, s_hprot_i, s_hmastlock_i)) begin
            w_addr_fail = 1'b1;
        end else if (s_haddr_i[31:AW+2] != BASE_ADDR[31:AW+2]) begin
            w_addr_fail = 1'b1;
        end else if (s_hsize_i > HSIZE_WORD) begin
            w_addr_fail = 1'b1;
        end else if (((s_hsize_i == HSIZE_HALF) && s_haddr_i[0]) ||
                     ((s_hsize_i == HSIZE_WORD) && (s_haddr_i[1:0] != 2'b00))) begin
            w_addr_fail = 1'b1;
        end else begin
            w_addr_fail = 1'b0;
        end
    end

    // Next-state and RAM strobes
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_rd_go     = 1'b0;
        w_wr_go     = 1'b0;
        case (r_state)
            WR_CHK: begin
                if (w_chk_ok) begin
                    w_state_nxt = WR_OK;
                    w_commit    = 1'b1;
                end else begin
                    w_state_nxt = ERR1;
                end
            end
            ERR1: w_state_nxt = ERR2;
            IDLE, WR_OK, ERR2: begin
                if (!w_accept) begin
                    w_state_nxt = IDLE;
                end else if (w_addr_fail) begin
                    w_state_nxt = ERR1;
                end else if (s_hwrite_i) begin
                    w_state_nxt = WR_CHK;
                    w_wr_go     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_rd_go     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    ahb_ram_bytemerge u_merge (
        .i_hsize  (r_wsize),
        .i_addr   (r_wlane),
        .i_old    (r_old),
        .i_new    (s_hwdata_i),
        .o_merged (w_merged)
    );

`ifdef PROT_RAM_STORE_ECC_EN
    // Full words keep the master's check bits; partial words are re-encoded after merge
    assign w_wword = (r_wsize == HSIZE_WORD) ? {s_hwchecksum_i, s_hwdata_i}
                                             : {secded_enc(w_merged), w_merged};
`else
    assign w_wword = w_merged;
`endif

    // State, handshake outputs and violation counter
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            r_state   <= IDLE;
            r_hready  <= 1'b1;
            r_hresp   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_hready <= (w_state_nxt != WR_CHK) && (w_state_nxt != ERR1);
            r_hresp  <= (w_state_nxt == ERR1) || (w_state_nxt == ERR2);
            r_err    <= (w_state_nxt == ERR1);
            if ((w_state_nxt == ERR1) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Read data path: word fetched at the accept edge, zero outside read data phases
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            r_hrdata <= 32'h0;
            r_hrchk  <= 7'h0;
        end else if (w_rd_go) begin
`ifdef PROT_RAM_STORE_ECC_EN
            r_hrdata <= r_mem[w_aidx][31:0];
            r_hrchk  <= r_mem[w_aidx][38:32];
`else
            r_hrdata <= r_mem[w_aidx];
            r_hrchk  <= secded_enc(r_mem[w_aidx]);
`endif
        end else begin
            r_hrdata <= 32'h0;
            r_hrchk  <= 7'h0;
        end
    end

    // Write capture at accept (old word read here) and commit after the checksum check
    always_ff @(posedge s_clk_i) begin
        if (w_wr_go) begin
            r_widx  <= w_aidx;
            r_wsize <= s_hsize_i;
            r_wlane <= s_haddr_i[1:0];
            r_old   <= r_mem[w_aidx][31:0];
        end
        if (s_resetn_i && w_commit) begin
            r_mem[r_widx] <= w_wword;
        end
    end

    assign s_hrdata_o     = r_hrdata;
    assign s_hrchecksum_o = r_hrchk;
    assign s_hready_o     = r_hready;
    assign s_hresp_o      = r_hresp;
    assign s_err_o        = r_err;
    assign s_err_cnt_o    = r_err_cnt;

endmodule
